int_reg_file: RTL and testbench



---
 rtl/int_reg_file_pkg.sv | 17 +
 rtl/int_reg_file_if.sv | 40 ++++
 rtl/int_reg_file_read_port.sv | 41 ++++
 rtl/int_reg_file.sv | 98 +++++++++
 tb/tb_int_reg_file.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/int_reg_file_pkg.sv
// Shared processor types for the integer register file:
// register/word types, sizes and the scrub state enum.
package int_reg_file_pkg;

  localparam int XLEN      = 32;
  localparam int REG_COUNT = 32;
  localparam int REG_AW    = $clog2(REG_COUNT);

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]   word_t;

  typedef enum logic {
    CLEAR,
    READY
  } reg_file_state_t;

endpackage

// File: rtl/int_reg_file_if.sv
// Register-file protocol bundle between the read/write stages
// (master) and the storage (slave): 2 read ports, 1 write port.
interface int_reg_file_if;
  import int_reg_file_pkg::*;

  logic      clearReq;
  logic      ready;
  reg_addr_t readAddr1;
  reg_addr_t readAddr2;
  word_t     readValue1;
  word_t     readValue2;
  reg_addr_t writeAddr;
  word_t     writeValue;
  logic      writeEnable;

  modport master (
    output clearReq,
    output readAddr1,
    output readAddr2,
    output writeAddr,
    output writeValue,
    output writeEnable,
    input  ready,
    input  readValue1,
    input  readValue2
  );

  modport slave (
    input  clearReq,
    input  readAddr1,
    input  readAddr2,
    input  writeAddr,
    input  writeValue,
    input  writeEnable,
    output ready,
    output readValue1,
    output readValue2
  );

endinterface

// File: rtl/int_reg_file_read_port.sv
// One registered read port with write-to-read bypass.
// Ports: clk, rst_n, en_i, rd_addr_i, mem_data_i, wr_* bypass in, rd_data_o.
module int_reg_file_read_port
  import int_reg_file_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      en_i,
  input  reg_addr_t rd_addr_i,
  input  word_t     mem_data_i,
  input  logic      wr_en_i,
  input  reg_addr_t wr_addr_i,
  input  word_t     wr_data_i,
  output word_t     rd_data_o
);

  word_t rd_data_d;
  word_t rd_data_q;

  always_comb begin
    rd_data_d = '0;
    if (!en_i || rd_addr_i == '0) begin
      rd_data_d = '0;
    end else if (wr_en_i && wr_addr_i == rd_addr_i) begin
      rd_data_d = wr_data_i;
    end else begin
      rd_data_d = mem_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/int_reg_file.sv
// Integer register file: x0 hardwired to zero, registered reads with bypass,
// scrub FSM zeroes all entries. Ports: clk, rstN, rf (int_reg_file_if.slave).
module int_reg_file
  import int_reg_file_pkg::*;
(
  input  logic           clk,
  input  logic           rstN,
  int_reg_file_if.slave  rf
);

  localparam reg_addr_t LAST_IDX = reg_addr_t'(REG_COUNT - 1);

  reg_file_state_t state_q;
  reg_file_state_t state_d;
  reg_addr_t       clear_idx_q;
  reg_addr_t       clear_idx_d;
  logic            in_service;
  logic            wr_en;

  word_t mem [REG_COUNT];

  assign in_service = (state_q == READY);
  assign rf.ready   = in_service;

  // A clear request in service wins over a same-cycle write,
  // so the dropped write is also not bypassed.
  assign wr_en = in_service
               && !rf.clearReq
               && rf.writeEnable
               && (rf.writeAddr != '0);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q     <= CLEAR;
      clear_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      clear_idx_q <= clear_idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clear_idx_d = clear_idx_q;
    unique case (state_q)
      CLEAR: begin
        if (rf.clearReq) begin
          clear_idx_d = '0;
        end else if (clear_idx_q == LAST_IDX) begin
          state_d     = READY;
          clear_idx_d = '0;
        end else begin
          clear_idx_d = clear_idx_q + 1'b1;
        end
      end
      READY: begin
        if (rf.clearReq) begin
          state_d     = CLEAR;
          clear_idx_d = '0;
        end
      end
    endcase
  end

  // Storage has no reset; the scrub provides the zero state.
  always_ff @(posedge clk) begin
    if (!in_service) begin
      mem[clear_idx_q] <= '0;
    end else if (wr_en) begin
      mem[rf.writeAddr] <= rf.writeValue;
    end
  end

  int_reg_file_read_port u_rd1 (
    .clk        (clk),
    .rst_n      (rstN),
    .en_i       (in_service),
    .rd_addr_i  (rf.readAddr1),
    .mem_data_i (mem[rf.readAddr1]),
    .wr_en_i    (wr_en),
    .wr_addr_i  (rf.writeAddr),
    .wr_data_i  (rf.writeValue),
    .rd_data_o  (rf.readValue1)
  );

  int_reg_file_read_port u_rd2 (
    .clk        (clk),
    .rst_n      (rstN),
    .en_i       (in_service),
    .rd_addr_i  (rf.readAddr2),
    .mem_data_i (mem[rf.readAddr2]),
    .wr_en_i    (wr_en),
    .wr_addr_i  (rf.writeAddr),
    .wr_data_i  (rf.writeValue),
    .rd_data_o  (rf.readValue2)
  );

endmodule

// File: tb/tb_int_reg_file.sv
// Directed self-checking bench for int_reg_file.
// Inputs change 1 time unit after the rising edge; outputs are checked there.
module tb_int_reg_file;
  import int_reg_file_pkg::*;

  logic clk;
  logic rstN;
  int   vectors;
  int   miscompares;

  int_reg_file_if rf_if ();

  int_reg_file dut (
    .clk  (clk),
    .rstN (rstN),
    .rf   (rf_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rf_if.clearReq    = 1'b0;
    rf_if.readAddr1   = '0;
    rf_if.readAddr2   = '0;
    rf_if.writeAddr   = '0;
    rf_if.writeValue  = '0;
    rf_if.writeEnable = 1'b0;
  endtask

  task automatic test_reset();
    int low_cnt;
    rstN = 1'b0;
    idle();
    repeat (3) tick();
    vectors++;
    if (rf_if.ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready: got %b want 0", rf_if.ready);
    end
    vectors++;
    if (rf_if.readValue1 !== 32'h0 || rf_if.readValue2 !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_rdata: got %h/%h want 0/0",
               rf_if.readValue1, rf_if.readValue2);
    end
    rstN = 1'b1;
    low_cnt = 0;
    for (int i = 1; i <= 32; i++) begin
      tick();
      if (rf_if.ready === 1'b0) low_cnt++;
    end
    vectors++;
    if (low_cnt != 31) begin
      miscompares++;
      $display("FAIL reset_low_cycles: got %0d want 31", low_cnt);
    end
    vectors++;
    if (rf_if.ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready_at_32: got %b want 1", rf_if.ready);
    end
  endtask

  task automatic test_write_read();
    rf_if.writeEnable = 1'b1;
    rf_if.writeAddr   = 5'd5;
    rf_if.writeValue  = 32'hDEADBEEF;
    rf_if.readAddr1   = 5'd0;
    tick();
    rf_if.writeEnable = 1'b0;
    rf_if.readAddr1   = 5'd5;
    tick();
    vectors++;
    if (rf_if.readValue1 !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL wr_rd_x5: got %h want deadbeef", rf_if.readValue1);
    end
    idle();
  endtask

  task automatic test_x0();
    rf_if.writeEnable = 1'b1;
    rf_if.writeAddr   = 5'd0;
    rf_if.writeValue  = 32'h12345678;
    rf_if.readAddr1   = 5'd0;
    rf_if.readAddr2   = 5'd0;
    tick();
    rf_if.writeEnable = 1'b0;
    vectors++;
    if (rf_if.readValue1 !== 32'h0 || rf_if.readValue2 !== 32'h0) begin
      miscompares++;
      $display("FAIL x0_same: got %h/%h want 0/0",
               rf_if.readValue1, rf_if.readValue2);
    end
    tick();
    vectors++;
    if (rf_if.readValue1 !== 32'h0 || rf_if.readValue2 !== 32'h0) begin
      miscompares++;
      $display("FAIL x0_next: got %h/%h want 0/0",
               rf_if.readValue1, rf_if.readValue2);
    end
    idle();
  endtask

  task automatic test_bypass();
    rf_if.writeEnable = 1'b1;
    rf_if.writeAddr   = 5'd7;
    rf_if.writeValue  = 32'hCAFEF00D;
    rf_if.readAddr1   = 5'd7;
    rf_if.readAddr2   = 5'd7;
    tick();
    rf_if.writeEnable = 1'b0;
    vectors++;
    if (rf_if.readValue1 !== 32'hCAFEF00D || rf_if.readValue2 !== 32'hCAFEF00D) begin
      miscompares++;
      $display("FAIL bypass_x7: got %h/%h want cafef00d/cafef00d",
               rf_if.readValue1, rf_if.readValue2);
    end
    tick();
    vectors++;
    if (rf_if.readValue1 !== 32'hCAFEF00D || rf_if.readValue2 !== 32'hCAFEF00D) begin
      miscompares++;
      $display("FAIL array_x7: got %h/%h want cafef00d/cafef00d",
               rf_if.readValue1, rf_if.readValue2);
    end
    idle();
  endtask

  task automatic test_read_all_zero(input string tag);
    int bad;
    bad = 0;
    for (int a = 0; a < 32; a++) begin
      rf_if.readAddr1 = reg_addr_t'(a);
      rf_if.readAddr2 = reg_addr_t'(31 - a);
      tick();
      vectors++;
      if (rf_if.readValue1 !== 32'h0 || rf_if.readValue2 !== 32'h0) begin
        miscompares++;
        $display("FAIL %s_x%0d: got %h/%h want 0/0",
                 tag, a, rf_if.readValue1, rf_if.readValue2);
      end
    end
    idle();
  endtask

  task automatic test_clear_req();
    int n;
    for (int a = 1; a < 32; a++) begin
      rf_if.writeEnable = 1'b1;
      rf_if.writeAddr   = reg_addr_t'(a);
      rf_if.writeValue  = 32'h1000_0000 | 32'(a);
      tick();
    end
    rf_if.writeEnable = 1'b0;
    rf_if.readAddr1   = 5'd31;
    rf_if.readAddr2   = 5'd3;
    tick();
    vectors++;
    if (rf_if.readValue1 !== 32'h1000001F || rf_if.readValue2 !== 32'h10000003) begin
      miscompares++;
      $display("FAIL fill_check: got %h/%h want 1000001f/10000003",
               rf_if.readValue1, rf_if.readValue2);
    end
    rf_if.clearReq    = 1'b1;
    rf_if.writeEnable = 1'b1;
    rf_if.writeAddr   = 5'd3;
    rf_if.writeValue  = 32'h000000AA;
    tick();
    rf_if.clearReq    = 1'b0;
    rf_if.writeEnable = 1'b0;
    vectors++;
    if (rf_if.ready !== 1'b0) begin
      miscompares++;
      $display("FAIL clr_ready_drop: got %b want 0", rf_if.ready);
    end
    n = 0;
    while (rf_if.ready !== 1'b1 && n < 100) begin
      rf_if.writeEnable = (n == 20);
      rf_if.writeAddr   = 5'd9;
      rf_if.writeValue  = 32'h00000055;
      tick();
      n++;
    end
    rf_if.writeEnable = 1'b0;
    vectors++;
    if (n != 32) begin
      miscompares++;
      $display("FAIL clr_scrub_len: got %0d want 32", n);
    end
    test_read_all_zero("clr_read");
  endtask

  task automatic test_reset_mid_scrub();
    int n;
    rf_if.writeEnable = 1'b1;
    rf_if.writeAddr   = 5'd4;
    rf_if.writeValue  = 32'h44444444;
    tick();
    rf_if.writeEnable = 1'b0;
    rf_if.readAddr1   = 5'd4;
    rf_if.readAddr2   = 5'd4;
    tick();
    vectors++;
    if (rf_if.readValue1 !== 32'h44444444) begin
      miscompares++;
      $display("FAIL pre_rst_x4: got %h want 44444444", rf_if.readValue1);
    end
    #2;
    rstN = 1'b0;
    #1;
    vectors++;
    if (rf_if.readValue1 !== 32'h0 || rf_if.readValue2 !== 32'h0 ||
        rf_if.ready !== 1'b0) begin
      miscompares++;
      $display("FAIL async_rst: got %h/%h rdy %b want 0/0 rdy 0",
               rf_if.readValue1, rf_if.readValue2, rf_if.ready);
    end
    tick();
    rstN = 1'b1;
    repeat (10) tick();
    vectors++;
    if (rf_if.ready !== 1'b0) begin
      miscompares++;
      $display("FAIL scrub10_ready: got %b want 0", rf_if.ready);
    end
    rstN = 1'b0;
    #1;
    vectors++;
    if (rf_if.readValue1 !== 32'h0 || rf_if.ready !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_scrub_rst: got %h rdy %b want 0 rdy 0",
               rf_if.readValue1, rf_if.ready);
    end
    tick();
    rstN = 1'b1;
    n = 0;
    while (rf_if.ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    vectors++;
    if (n != 32) begin
      miscompares++;
      $display("FAIL rescrub_len: got %0d want 32", n);
    end
    test_read_all_zero("rst_read");
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rstN        = 1'b0;
    idle();
    test_reset();
    test_write_read();
    test_x0();
    test_bypass();
    test_clear_req();
    test_reset_mid_scrub();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
